// File: rtl/hazard_pkg.sv
// Shared types and defaults for the N-way hazard unit and its load scoreboard.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_t;

  localparam int unsigned DEF_LANES     = 2;
  localparam int unsigned DEF_REGW      = 5;
  localparam int unsigned DEF_LOAD_LAT  = 2;
  localparam int unsigned DEF_FLUSH_CYC = 1;

  localparam int unsigned STALL_W = 32;

  // A count of n states needs clog2(n) bits, but never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned SB_W_DEF   = cnt_width(DEF_LOAD_LAT);
  localparam int unsigned HOLD_W_DEF = cnt_width(DEF_FLUSH_CYC);

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of loads still in flight; busy while the count is nonzero.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned REGW     = DEF_REGW,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      set_en,
  input  logic [LANES*REGW-1:0] set_reg,
  input  logic                  dec,
  output logic [(1<<REGW)-1:0]  busy
);

  localparam int unsigned NREG = 1 << REGW;
  localparam int unsigned SBW  = cnt_width(LOAD_LAT);
  localparam logic [SBW-1:0] SET_VAL = SBW'(LOAD_LAT - 1);

  logic [NREG-1:0][SBW-1:0] entry;
  logic [NREG-1:0]          hit;

  // A one-cycle load latency is fully covered by Execute-stage matching.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (set_en[i] && (LOAD_LAT > 1)) hit[set_reg[i*REGW +: REGW]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (hit[r]) entry[r] <= SET_VAL;
        else if (dec && (entry[r] != '0)) entry[r] <= entry[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NREG; r++) busy[r] = (entry[r] != '0);
  end

endmodule

// File: rtl/hazard_unit_nway.sv
// N-way issue hazard unit: redirect/flush control, load-use and intra-bundle stalls.
module hazard_unit_nway
  import hazard_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned REGW      = DEF_REGW,
  parameter int unsigned LOAD_LAT  = DEF_LOAD_LAT,
  parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      branch_e,
  input  logic [LANES-1:0]      taken_e,
  input  logic [LANES-1:0]      pred_e,
  input  logic [LANES-1:0]      pcsrc_e,
  input  logic [LANES-1:0]      mem_read_e,
  input  logic [LANES*REGW-1:0] wr_reg_e,
  input  logic [LANES*REGW-1:0] rs_d,
  input  logic [LANES*REGW-1:0] rt_d,
  input  logic [LANES*REGW-1:0] wr_reg_d,
  input  logic [LANES-1:0]      reg_write_d,
  output logic [LANES-1:0]      stall_d,
  output logic [LANES-1:0]      flush,
  output logic [LANES-1:0]      cpc,
  output logic                  redirect_busy,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam int unsigned HW = cnt_width(FLUSH_CYC);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(FLUSH_CYC - 1);

  hold_state_t state, state_next;
  logic [HW-1:0] hold_cnt, hold_cnt_next;

  logic [LANES-1:0]       mispred, redir_lane, wrong_path, live_load, sb_set;
  logic [LANES-1:0]       hazard, stall_raw;
  logic [(1<<REGW)-1:0]   sb_busy;
  logic                   redirect, flush_active, found_m, found_r, chain;
  logic [REGW-1:0]        rs, rt, wr;

  // Lanes younger than the oldest redirecting lane are on the wrong path.
  always_comb begin
    mispred    = branch_e & (taken_e ^ pred_e);
    redir_lane = mispred | pcsrc_e;
    redirect   = |redir_lane;
    cpc        = '0;
    wrong_path = '0;
    found_m    = 1'b0;
    found_r    = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mispred[i] && !found_m) begin
        cpc[i]  = 1'b1;
        found_m = 1'b1;
      end
      wrong_path[i] = found_r;
      if (redir_lane[i]) found_r = 1'b1;
    end
    live_load = mem_read_e & ~wrong_path;
    sb_set    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sb_set[i] = live_load[i] && (wr_reg_e[i*REGW +: REGW] != '0);
    end
  end

  load_scoreboard #(
    .LANES    (LANES),
    .REGW     (REGW),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set),
    .set_reg (wr_reg_e),
    .dec     (1'b1),
    .busy    (sb_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Leaving HOLD coincides with the counter stepping from 1 to 0.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    if (redirect && (FLUSH_CYC > 1)) begin
      state_next    = ST_HOLD;
      hold_cnt_next = HOLD_LOAD;
    end else if (state == ST_HOLD) begin
      if (hold_cnt <= HW'(1)) begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end else begin
        hold_cnt_next = hold_cnt - 1'b1;
      end
    end
    redirect_busy = (state == ST_HOLD);
    flush_active  = redirect || (state == ST_HOLD);
    flush         = flush_active ? '1 : '0;
  end

  always_comb begin
    hazard = '0;
    rs     = '0;
    rt     = '0;
    wr     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rs = rs_d[i*REGW +: REGW];
      rt = rt_d[i*REGW +: REGW];
      for (int unsigned j = 0; j < LANES; j++) begin
        wr = wr_reg_e[j*REGW +: REGW];
        if (live_load[j] && (((rs != '0) && (rs == wr)) || ((rt != '0) && (rt == wr))))
          hazard[i] = 1'b1;
      end
      if ((rs != '0) && sb_busy[rs]) hazard[i] = 1'b1;
      if ((rt != '0) && sb_busy[rt]) hazard[i] = 1'b1;
      for (int unsigned k = 0; k < LANES; k++) begin
        wr = wr_reg_d[k*REGW +: REGW];
        if ((k < i) && reg_write_d[k] && (wr != '0) && ((wr == rs) || (wr == rt)))
          hazard[i] = 1'b1;
      end
    end
  end

  always_comb begin
    stall_raw = '0;
    chain     = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      chain        = chain | hazard[i];
      stall_raw[i] = chain;
    end
    stall_d = flush_active ? '0 : stall_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((|stall_d) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_nway.sv
// Bench for hazard_unit_nway: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_unit_nway;

  localparam int L  = 2;
  localparam int RW = 5;
  localparam int LL = 2;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [L-1:0]    branch_e, taken_e, pred_e, pcsrc_e, mem_read_e, reg_write_d;
  logic [L*RW-1:0] wr_reg_e, rs_d, rt_d, wr_reg_d;
  logic [L-1:0]    stall_d, flush, cpc;
  logic            redirect_busy;
  logic [31:0]     stall_cnt;

  int tests = 0;
  int fails = 0;

  int     m_sb [32];
  int     m_hold = 0;
  longint m_cnt  = 0;

  hazard_unit_nway #(
    .LANES     (L),
    .REGW      (RW),
    .LOAD_LAT  (LL),
    .FLUSH_CYC (FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_e      (branch_e),
    .taken_e       (taken_e),
    .pred_e        (pred_e),
    .pcsrc_e       (pcsrc_e),
    .mem_read_e    (mem_read_e),
    .wr_reg_e      (wr_reg_e),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .wr_reg_d      (wr_reg_d),
    .reg_write_d   (reg_write_d),
    .stall_d       (stall_d),
    .flush         (flush),
    .cpc           (cpc),
    .redirect_busy (redirect_busy),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from current inputs and model state.
  function automatic void model(output logic [L-1:0] e_stall, output logic [L-1:0] e_flush,
                                output logic [L-1:0] e_cpc, output logic e_busy,
                                output int red_lane);
    int   r, m, src;
    logic any, haz, misp;
    r   = -1;
    m   = -1;
    any = 1'b0;
    for (int l = 0; l < L; l++) begin
      misp = branch_e[l] && (taken_e[l] != pred_e[l]);
      if (m < 0 && misp) m = l;
      if (r < 0 && (misp || pcsrc_e[l])) r = l;
    end
    e_cpc = '0;
    if (m >= 0) e_cpc[m] = 1'b1;
    e_busy  = (m_hold > 0);
    e_flush = (r >= 0 || m_hold > 0) ? '1 : '0;
    e_stall = '0;
    for (int i = 0; i < L; i++) begin
      haz = 1'b0;
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? int'(rs_d[i*RW +: RW]) : int'(rt_d[i*RW +: RW]);
        if (src != 0) begin
          for (int j = 0; j < L; j++)
            if (mem_read_e[j] && !(r >= 0 && j > r) && int'(wr_reg_e[j*RW +: RW]) == src) haz = 1'b1;
          if (m_sb[src] > 0) haz = 1'b1;
          for (int k = 0; k < i; k++)
            if (reg_write_d[k] && int'(wr_reg_d[k*RW +: RW]) == src) haz = 1'b1;
        end
      end
      any = any | haz;
      e_stall[i] = any;
    end
    if (e_flush != '0) e_stall = '0;
    red_lane = r;
  endfunction

  logic [L-1:0] us, uf, uc;
  logic         ub;
  int           ur, uw;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_sb[i]) m_sb[i] = 0;
      m_hold = 0;
      m_cnt  = 0;
    end else begin
      model(us, uf, uc, ub, ur);
      if (us != '0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (ur >= 0) m_hold = FC - 1;
      else if (m_hold > 0) m_hold--;
      foreach (m_sb[i]) if (m_sb[i] > 0) m_sb[i]--;
      for (int j = 0; j < L; j++) begin
        uw = int'(wr_reg_e[j*RW +: RW]);
        if (mem_read_e[j] && !(ur >= 0 && j > ur) && uw != 0) m_sb[uw] = LL - 1;
      end
    end
  end

  logic [L-1:0] cs, cf, cc;
  logic         cb;
  int           cr;

  always @(negedge clk) begin
    #2;
    model(cs, cf, cc, cb, cr);
    check("m_stall_d", 32'(stall_d), 32'(cs));
    check("m_flush", 32'(flush), 32'(cf));
    check("m_cpc", 32'(cpc), 32'(cc));
    check("m_redirect_busy", 32'(redirect_busy), 32'(cb));
    check("m_stall_cnt", stall_cnt, 32'(m_cnt));
  end

  task automatic clear_in();
    branch_e = '0; taken_e = '0; pred_e = '0; pcsrc_e = '0; mem_read_e = '0;
    reg_write_d = '0; wr_reg_e = '0; rs_d = '0; rt_d = '0; wr_reg_d = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clear_in();
  endtask

  function automatic logic [RW-1:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 4));
  endfunction

  task automatic rand_inputs();
    for (int l = 0; l < L; l++) begin
      branch_e[l]    = ($urandom_range(0, 7) == 0);
      taken_e[l]     = 1'($urandom);
      pred_e[l]      = 1'($urandom);
      pcsrc_e[l]     = ($urandom_range(0, 15) == 0);
      mem_read_e[l]  = ($urandom_range(0, 2) == 0);
      reg_write_d[l] = 1'($urandom);
      wr_reg_e[l*RW +: RW] = rnd_reg();
      rs_d[l*RW +: RW]     = rnd_reg();
      rt_d[l*RW +: RW]     = rnd_reg();
      wr_reg_d[l*RW +: RW] = rnd_reg();
    end
  endtask

  initial begin
    clear_in();
    step(); #3;
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_busy", 32'(redirect_busy), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    step(); rst = 1'b1;

    // load in E lane0 -> r5, D lane1 reads r5
    step(); mem_read_e = 2'b01; wr_reg_e[0 +: RW] = 5'd5; rs_d[RW +: RW] = 5'd5; #3;
    check("lu_e_stall", 32'(stall_d), 32'b10);
    check("lu_e_cnt", stall_cnt, 32'd0);
    step(); rs_d[RW +: RW] = 5'd5; #3;
    check("lu_sb_stall", 32'(stall_d), 32'b10);
    check("lu_sb_cnt", stall_cnt, 32'd1);
    step(); rs_d[RW +: RW] = 5'd5; #3;
    check("lu_done_stall", 32'(stall_d), 32'b00);
    check("lu_done_cnt", stall_cnt, 32'd2);

    // intra-bundle dependency on r3
    step(); reg_write_d = 2'b01; wr_reg_d[0 +: RW] = 5'd3; rt_d[RW +: RW] = 5'd3; #3;
    check("ib_stall", 32'(stall_d), 32'b10);
    check("ib_cnt0", stall_cnt, 32'd2);
    step(); #3;
    check("ib_cnt1", stall_cnt, 32'd3);

    // both lanes mispredict, decode hazard must be suppressed
    step(); branch_e = 2'b11; taken_e = 2'b11; reg_write_d = 2'b01;
    wr_reg_d[0 +: RW] = 5'd3; rt_d[RW +: RW] = 5'd3; #3;
    check("mp_cpc", 32'(cpc), 32'b01);
    check("mp_flush0", 32'(flush), 32'b11);
    check("mp_busy0", 32'(redirect_busy), 32'd0);
    check("mp_stall0", 32'(stall_d), 32'b00);
    step(); reg_write_d = 2'b01; wr_reg_d[0 +: RW] = 5'd3; rt_d[RW +: RW] = 5'd3; #3;
    check("mp_flush1", 32'(flush), 32'b11);
    check("mp_busy1", 32'(redirect_busy), 32'd1);
    check("mp_stall1", 32'(stall_d), 32'b00);
    step(); #3;
    check("mp_flush2", 32'(flush), 32'b00);
    check("mp_busy2", 32'(redirect_busy), 32'd0);
    check("mp_cnt", stall_cnt, 32'd3);

    // jump in lane0 makes lane1 load wrong-path
    step(); pcsrc_e = 2'b01; mem_read_e = 2'b10; wr_reg_e[RW +: RW] = 5'd7; #3;
    check("jp_flush", 32'(flush), 32'b11);
    check("jp_cpc", 32'(cpc), 32'b00);
    step(); rs_d[0 +: RW] = 5'd7; #3;
    check("jp_stall1", 32'(stall_d), 32'b00);
    step(); rs_d[0 +: RW] = 5'd7; #3;
    check("jp_stall2", 32'(stall_d), 32'b00);

    // r0 never creates a hazard
    step(); mem_read_e = 2'b01; reg_write_d = 2'b01; #3;
    check("r0_stall", 32'(stall_d), 32'b00);

    // lane0 hazard stalls the younger lane too
    step(); mem_read_e = 2'b01; wr_reg_e[0 +: RW] = 5'd9; rs_d[0 +: RW] = 5'd9; #3;
    check("chain_stall", 32'(stall_d), 32'b11);
    check("chain_cnt0", stall_cnt, 32'd3);
    step(); rt_d[RW +: RW] = 5'd9; #3;
    check("chain_sb_stall", 32'(stall_d), 32'b10);
    check("chain_cnt1", stall_cnt, 32'd4);
    step(); #3;
    check("chain_cnt2", stall_cnt, 32'd5);

    // async reset in the middle of HOLD
    step(); branch_e = 2'b01; taken_e = 2'b01; #3;
    check("ar_cpc", 32'(cpc), 32'b01);
    step(); #1;
    check("ar_hold_flush", 32'(flush), 32'b11);
    check("ar_hold_busy", 32'(redirect_busy), 32'd1);
    check("ar_hold_cnt", stall_cnt, 32'd5);
    #2 rst = 1'b0;
    #1;
    check("ar_flush", 32'(flush), 32'b00);
    check("ar_busy", 32'(redirect_busy), 32'd0);
    check("ar_cnt", stall_cnt, 32'd0);
    step();
    step(); rst = 1'b1;

    repeat (3000) begin
      @(negedge clk);
      rand_inputs();
    end
    step();
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit_nway.md
HAZARD_UNIT_NWAY -- requirements
Module: hazard_unit_nway

Interface
REQ-001 Parameter LANES, default 2: issue width; lane 0 is the oldest instruction.
REQ-002 Parameter REGW, default 5: register-index width.
REQ-003 Parameter LOAD_LAT, default 2 (range 1..7): cycles from a load in Execute until its result can be forwarded.
REQ-004 Parameter FLUSH_CYC, default 1 (range 1..15): cycles for which flush is held after a redirect.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 branch_e  input  LANES  lane in Execute is a conditional branch.
REQ-008 taken_e  input  LANES  resolved branch outcome.
REQ-009 pred_e  input  LANES  predicted outcome carried to Execute.
REQ-010 pcsrc_e  input  LANES  unconditional redirect (jump) in Execute.
REQ-011 mem_read_e  input  LANES  lane in Execute is a load.
REQ-012 wr_reg_e  input  LANES*REGW  destination register per Execute lane.
REQ-013 rs_d, rt_d  input  LANES*REGW each  source registers per Decode lane.
REQ-014 wr_reg_d  input  LANES*REGW  destination register per Decode lane.
REQ-015 reg_write_d  input  LANES  Decode lane writes a register.
REQ-016 stall_d  output  LANES  hold Decode lane and Fetch.
REQ-017 flush  output  LANES  squash Fetch/Decode lane.
REQ-018 cpc  output  LANES  one-hot correct-PC select for the oldest mispredicting lane.
REQ-019 redirect_busy  output  1  flush hold in progress.
REQ-020 stall_cnt  output  32  performance counter of stall cycles.

Function
REQ-021 Lane i mispredicts when branch_e[i] & (taken_e[i] ^ pred_e[i]).
REQ-022 cpc is combinational and one-hot on the lowest-index mispredicting lane; it is all-zero when no lane mispredicts.
REQ-023 A redirect event occurs when any lane mispredicts or any pcsrc_e bit is set.
REQ-024 Let R be the lowest-index lane that mispredicts or has pcsrc_e set; Execute lanes with index > R are wrong-path.
REQ-025 On a redirect event, all flush bits assert combinationally in the same cycle.
REQ-026 FSM states: IDLE and HOLD; a redirect event with FLUSH_CYC>1 loads the hold counter with FLUSH_CYC-1 and enters HOLD.
REQ-027 In HOLD, all flush bits and redirect_busy are 1; the counter decrements each cycle and the FSM returns to IDLE when it reaches 0.
REQ-028 A new redirect event during HOLD reloads the counter to FLUSH_CYC-1.
REQ-029 With FLUSH_CYC=1, HOLD is never entered.
REQ-030 Scoreboard: one counter per register, width clog2(LOAD_LAT).
REQ-031 A non-wrong-path lane with mem_read_e=1 and wr_reg_e≠0 sets its entry to LOAD_LAT-1 at the next edge; no set occurs when LOAD_LAT=1.
REQ-032 All nonzero scoreboard entries decrement by 1 each cycle; a set wins over a decrement on the same entry; several lanes setting the same entry is legal.
REQ-033 Lane i has a load-use hazard when a nonzero rs_d[i] or rt_d[i] matches either of:
 - a non-wrong-path Execute load's wr_reg_e;
 - a nonzero scoreboard entry.
REQ-034 Lane i has an intra-bundle hazard when some k<i has reg_write_d[k], wr_reg_d[k]≠0, and wr_reg_d[k] equal to rs_d[i] or rt_d[i].
REQ-035 Stalls are in-order: stall_d[i] = hazard_i | stall_d[i-1].
REQ-036 Flush (a redirect event or HOLD) forces stall_d to all-zero.
REQ-037 stall_cnt increments on every cycle with any stall_d bit set and saturates at 2^32-1.

Reset
REQ-038 While rst=0:
 - scoreboard entries, hold counter and stall_cnt are 0;
 - the FSM is IDLE and redirect_busy is 0.
REQ-039 Reset asserted mid-HOLD or with pending scoreboard entries clears them immediately; combinational outputs then depend only on the current inputs.

Structure
REQ-040 Package hazard_pkg holds:
 - the FSM state enum;
 - the default LANES, REGW, LOAD_LAT and FLUSH_CYC values;
 - the counter-width localparams.
REQ-041 The scoreboard is the sub-module load_scoreboard, with set ports per lane, a decrement, and a per-register busy vector.

Verification (LANES=2, REGW=5, LOAD_LAT=2, FLUSH_CYC=2)
REQ-042 Load in E lane0 writing r5, D lane1 rs=r5 -> stall_d=10 that cycle; next cycle scoreboard busy -> stall_d=10; third cycle stall_d=00.
REQ-043 D lane0 writes r3, D lane1 rt=r3 -> stall_d=10 and stall_cnt increments by 1.
REQ-044 Both lanes mispredict -> cpc=01; flush=11 for 2 cycles; redirect_busy=1 in the 2nd cycle only.
REQ-045 Lane0 jump with a lane1 load writing r7 -> no scoreboard set; D rs=r7 the next cycle -> stall_d=00.
REQ-046 Load writing r0, D rs=r0 -> stall_d=00.
REQ-047 rst=0 asynchronously during HOLD -> flush, redirect_busy and stall_cnt drop to 0 before the next edge.
